// File: rtl/sram64_port_arbiter.sv
// Arbitrates one 64-bit single-port SRAM between the fetch and data requesters.
// Build option ARB_ROUND_ROBIN_EN selects round-robin; default is data priority with a fetch starvation guard.
module sram64_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [63:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [63:0]       if_rdata,
  input  logic              d_req,
  input  logic [63:0]       d_addr,
  input  logic [7:0]        d_wea,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic              sram_en,
  output logic [7:0]        sram_wea,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [63:0]       sram_dina,
  input  logic [63:0]       sram_douta
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned WEA_W  = 8;
  localparam int unsigned IDX_LO = 3;
  localparam int unsigned IDX_HI = ADDR_W + IDX_LO - 1;

  logic              if_win_c;
  logic              pend_if;
  logic              pend_d;
  logic              pend_d_rd;
  logic [ADDR_W-1:0] if_idx_c;
  logic [ADDR_W-1:0] d_idx_c;
  logic              unused_addr_bits;

  assign if_idx_c = if_addr[IDX_HI:IDX_LO];
  assign d_idx_c  = d_addr[IDX_HI:IDX_LO];

  // Byte offset and bits above the SRAM index carry no meaning here.
  assign unused_addr_bits = ^{if_addr[DATA_W-1:IDX_HI+1], if_addr[IDX_LO-1:0],
                              d_addr[DATA_W-1:IDX_HI+1], d_addr[IDX_LO-1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [0:0] LAST_IF = 1'b0;
  localparam logic [0:0] LAST_D  = 1'b1;

  logic [0:0] last_gnt;

  // On a conflict the side that did not win most recently goes next.
  assign if_win_c = if_req & (~d_req | (last_gnt == LAST_D));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= LAST_IF;
    end else if (if_gnt) begin
      last_gnt <= LAST_IF;
    end else if (d_gnt) begin
      last_gnt <= LAST_D;
    end
  end
`else
  localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved_c;

  // Data wins conflicts until fetch has been refused STARVE_LIMIT cycles in a row.
  assign starved_c = (starve_cnt == CNT_MAX);
  assign if_win_c  = if_req & (~d_req | starved_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_req & ~if_gnt) begin
      if (!starved_c) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  assign if_gnt = ~rst & if_win_c;
  assign d_gnt  = ~rst & d_req & ~if_win_c;

  // SRAM port steering from the single winner.
  always_comb begin
    sram_en   = 1'b0;
    sram_wea  = '0;
    sram_addr = '0;
    sram_dina = '0;
    if (if_gnt) begin
      sram_en   = 1'b1;
      sram_addr = if_idx_c;
    end else if (d_gnt) begin
      sram_en   = 1'b1;
      sram_wea  = d_wea;
      sram_addr = d_idx_c;
      sram_dina = d_wdata;
    end
  end

  // Remembers who owns the SRAM read data returning next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_if   <= 1'b0;
      pend_d    <= 1'b0;
      pend_d_rd <= 1'b0;
    end else begin
      pend_if   <= if_gnt;
      pend_d    <= d_gnt;
      pend_d_rd <= d_gnt & (d_wea == WEA_W'(0));
    end
  end

  assign if_rvalid = ~rst & pend_if;
  assign d_rvalid  = ~rst & pend_d;
  assign if_rdata  = if_rvalid ? sram_douta : DATA_W'(0);
  assign d_rdata   = (d_rvalid & pend_d_rd) ? sram_douta : DATA_W'(0);

endmodule

// File: doc/sram64_port_arbiter.md
# sram64_port_arbiter

Arbitrates a single-ported 64-bit synchronous SRAM between the instruction-fetch requester and the data (load/store) requester of the pipeline. Requests are granted in the same cycle and answered one cycle later. Byte-lane formatting of store data and load extraction stay with the load/store unit. This block only schedules port ownership, steers responses back to the winning requester and prevents fetch starvation.

## Interface

**Parameters**
- `ADDR_W`, default 16: doubleword index width driven to the SRAM.
- `STARVE_LIMIT`, default 3: consecutive denied fetch cycles after which fetch wins a conflict. Legal range is ≥1.

**Ports** (clock and reset first)
- `clk` input 1: single clock; every flop is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `if_req` input 1: fetch request.
- `if_addr` input 64: fetch byte address; bits [2:0] are ignored.
- `if_gnt` output 1: fetch request accepted this cycle.
- `if_rvalid` output 1: fetch read data valid.
- `if_rdata` output 64: fetch read data.
- `d_req` input 1: data request.
- `d_addr` input 64: data byte address; bits [2:0] are ignored.
- `d_wea` input 8: byte write enables, already lane-aligned. Nonzero means a store; zero means a load.
- `d_wdata` input 64: store data, already lane-aligned.
- `d_gnt` output 1: data request accepted this cycle.
- `d_rvalid` output 1: load data valid, or store completion.
- `d_rdata` output 64: load data; 0 on a store completion.
- `sram_en` output 1: SRAM access enable.
- `sram_wea` output 8: SRAM byte write enables.
- `sram_addr` output ADDR_W: SRAM doubleword index, equal to the granted address bits [ADDR_W+2:3].
- `sram_dina` output 64: SRAM write data.
- `sram_douta` input 64: SRAM read data, valid one cycle after `sram_en`.

## Operation

**Grant logic** (combinational, same cycle)
- Only one requester → it is granted.
- Both requesting → the data port wins. Exception: fetch wins when `starve_cnt == STARVE_LIMIT`.
- `sram_en = if_gnt | d_gnt`.
- `sram_wea = d_gnt ? d_wea : 0`.
- `sram_dina = d_gnt ? d_wdata : 0`.
- `sram_addr` comes from the granted address; it is 0 when nothing is granted.
- At most one of `if_gnt` / `d_gnt` is ever high.

**Starvation counter** `starve_cnt`
- Width is $clog2(STARVE_LIMIT+1).
- Increments, saturating at `STARVE_LIMIT`, on every cycle with `if_req & ~if_gnt`.
- Clears on `if_gnt`, or on a cycle with `if_req` low.

**Response tracking**
- A registered `resp_sel` flop pair (fetch-pending, data-pending) captures the grants.
- Next cycle, the pending side raises `rvalid`.
- Read data: `if_rdata` / `d_rdata` = `sram_douta` when that side's `rvalid` is high and the access was a read; 0 otherwise.
- Stores produce a `d_rvalid` pulse with `d_rdata = 0`.
- Responses cannot be back-pressured. Requesters must accept `rvalid` unconditionally.

**Requester obligations**
- Hold `req` and the request fields stable until `gnt`.
- A request with `gnt` low is not consumed.

**Reset**
- While `rst` is high, every output is forced to 0 combinationally: gnt, rvalid, rdata, sram_*.
- At the clock edge, `starve_cnt`, the `resp_sel` flops and the round-robin pointer (if compiled in) clear.
- A response pending when `rst` rises is dropped; no `rvalid` appears after reset deasserts.

## Timing
- Grant latency is 0 cycles: `gnt` is in the same cycle as `req` when the port is won.
- Read latency is 1 cycle: `rvalid` and `rdata` appear in the cycle after `gnt`.
- Throughput is one access per cycle. Back-to-back grants to the same or alternating requesters are legal, and responses pipeline.
- Store immediately followed by a load to the same doubleword: the load returns the new data, because the SRAM is write-first.
- Worst-case fetch wait under continuous data traffic is `STARVE_LIMIT` cycles; fetch is granted on cycle `STARVE_LIMIT+1`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Fixed priority and `starve_cnt` are removed.
  - A 1-bit `last_gnt` register (reset value = fetch) records the most recent winner.
  - On a conflict, the side not in `last_gnt` wins. `last_gnt` updates on every grant.
  - The first conflict after reset therefore goes to data.
- `ARB_ROUND_ROBIN_EN` undefined: data-priority with the starvation guard, as described above.

## Test plan
- Fetch only: `if_req` with `if_addr = 0x48` → `if_gnt` in the same cycle, `sram_addr = 9`, `sram_en = 1`, `sram_wea = 0`; next cycle `if_rvalid = 1` and `if_rdata` equals the preloaded word at index 9.
- Store then load: data store `d_wea = 8'h0F`, `d_wdata = 0x11223344`, `d_addr = 0x100`; next cycle a load from 0x100 → `d_rvalid` pulses with `d_rdata = 0` for the store, then `d_rdata[31:0] = 0x11223344` for the load.
- Starvation, default build, `STARVE_LIMIT = 3`: both requesting continuously → `d_gnt` for cycles 1–3, `if_gnt` on cycle 4, `starve_cnt` returns to 0, then `d_gnt` again on cycle 5.
- Round-robin build (`ARB_ROUND_ROBIN_EN`): both requesting continuously from reset → grants alternate data, fetch, data, fetch; each `rvalid` lands on the matching side one cycle later.
- Reset mid-operation: `rst` asserted in the cycle after a fetch grant → `if_rvalid = 0` during reset and after release. All outputs are 0 while `rst = 1`.
- Idle: no requests for 10 cycles → `sram_en = 0`, both `rvalid` = 0, `starve_cnt = 0`.
